// File: rtl/box_motion_sequencer.sv
// box_motion_sequencer: per-frame erase/advance/redraw command generator for the rectangle draw engine
module box_motion_sequencer #(
    parameter int          SCREEN_W    = 480,
    parameter int          SCREEN_H    = 360,
    parameter int          BOX_SIZE    = 10,
    parameter int          FRAME_TICKS = 833333,
    parameter logic [2:0]  BOX_COLOUR  = 3'b001,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter int          START_X     = 0,
    parameter int          START_Y     = 0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    output logic       draw_start,
    input  logic       draw_done,
    output logic [9:0] rect_x,
    output logic [8:0] rect_y,
    output logic [2:0] rect_colour,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       busy,
    output logic       frame_overrun
);
    localparam int         CW    = FRAME_TICKS > 1 ? $clog2(FRAME_TICKS) : 1;
    localparam logic [9:0] MAX_X = 10'(SCREEN_W - BOX_SIZE);
    localparam logic [8:0] MAX_Y = 9'(SCREEN_H - BOX_SIZE);
    localparam logic [9:0] S_X   = 10'(START_X);
    localparam logic [8:0] S_Y   = 9'(START_Y);

    typedef enum logic [2:0] {IDLE, DRAW_REQ, DRAW_WAIT, WAIT_TICK, ERASE_REQ, ERASE_WAIT, UPDATE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] tick_cnt;
    logic          counting, tick, tick_pending, consume, req;
    logic          dir_x, dir_y;
    logic [9:0]    rect_x_q;
    logic [8:0]    rect_y_q;
    logic [2:0]    colour_q;

    assign counting = state != IDLE && enable;
    assign tick     = counting && tick_cnt == CW'(FRAME_TICKS - 1);
    assign req      = state == DRAW_REQ || state == ERASE_REQ;
    assign consume  = state == WAIT_TICK && state_nxt == ERASE_REQ;

    // next state and engine-facing outputs; rect follows pos during a request, then holds the latched copy
    always_comb begin
        state_nxt   = state;
        draw_start  = req;
        busy        = req || state == DRAW_WAIT || state == ERASE_WAIT;
        rect_x      = req ? pos_x : rect_x_q;
        rect_y      = req ? pos_y : rect_y_q;
        rect_colour = state == DRAW_REQ ? BOX_COLOUR : state == ERASE_REQ ? BG_COLOUR : colour_q;
        case (state)
            IDLE:       state_nxt = enable ? DRAW_REQ : IDLE;
            DRAW_REQ:   state_nxt = DRAW_WAIT;
            DRAW_WAIT:  state_nxt = draw_done ? WAIT_TICK : DRAW_WAIT;
            WAIT_TICK:  state_nxt = (tick_pending || tick) && enable ? ERASE_REQ : WAIT_TICK;
            ERASE_REQ:  state_nxt = ERASE_WAIT;
            ERASE_WAIT: state_nxt = draw_done ? UPDATE : ERASE_WAIT;
            UPDATE:     state_nxt = DRAW_REQ;
            default:    state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // frame tick counter, one-deep pending tick and sticky overrun flag
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tick_cnt      <= '0;
            tick_pending  <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            if (counting) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (consume) tick_pending <= 1'b0;
            else if (tick) begin
                if (tick_pending) frame_overrun <= 1'b1;
                tick_pending <= 1'b1;
            end
        end
    end

    // box position with per-axis bounce at the screen edges (dir 1 = +1, 0 = -1)
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pos_x <= S_X;
            pos_y <= S_Y;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (state == UPDATE) begin
            if (dir_x && pos_x == MAX_X) begin
                dir_x <= 1'b0;
                pos_x <= pos_x - 10'd1;
            end else if (!dir_x && pos_x == '0) begin
                dir_x <= 1'b1;
                pos_x <= pos_x + 10'd1;
            end else pos_x <= dir_x ? pos_x + 10'd1 : pos_x - 10'd1;
            if (dir_y && pos_y == MAX_Y) begin
                dir_y <= 1'b0;
                pos_y <= pos_y - 9'd1;
            end else if (!dir_y && pos_y == '0) begin
                dir_y <= 1'b1;
                pos_y <= pos_y + 9'd1;
            end else pos_y <= dir_y ? pos_y + 9'd1 : pos_y - 9'd1;
        end
    end

    // capture the request's rectangle so it stays stable while the engine works
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rect_x_q <= S_X;
            rect_y_q <= S_Y;
            colour_q <= BG_COLOUR;
        end else if (req) begin
            rect_x_q <= pos_x;
            rect_y_q <= pos_y;
            colour_q <= rect_colour;
        end
    end
endmodule

// File: tb/tb_box_motion_sequencer.sv
// tb_box_motion_sequencer: directed checks of draw/erase sequencing, bounce, overrun, enable hold and reset abandon
module tb_box_motion_sequencer;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       resetn, enable, draw_done;
    logic       a_start, a_busy, a_ovr;
    logic [9:0] a_rect_x, a_pos_x;
    logic [8:0] a_rect_y, a_pos_y;
    logic [2:0] a_col;

    logic       bc_resetn, bc_enable, bc_done;
    logic       b_start, b_busy, b_ovr, c_start, c_busy, c_ovr;
    logic [9:0] b_rect_x, b_pos_x, c_rect_x, c_pos_x;
    logic [8:0] b_rect_y, b_pos_y, c_rect_y, c_pos_y;
    logic [2:0] b_col, c_col;

    int errors = 0;
    int checks = 0;

    box_motion_sequencer #(.FRAME_TICKS(20)) dut_a (
        .clock(clock), .resetn(resetn), .enable(enable), .draw_start(a_start), .draw_done(draw_done),
        .rect_x(a_rect_x), .rect_y(a_rect_y), .rect_colour(a_col), .pos_x(a_pos_x), .pos_y(a_pos_y),
        .busy(a_busy), .frame_overrun(a_ovr));

    box_motion_sequencer #(.SCREEN_W(40), .SCREEN_H(30), .FRAME_TICKS(20), .START_X(30), .START_Y(19)) dut_b (
        .clock(clock), .resetn(bc_resetn), .enable(bc_enable), .draw_start(b_start), .draw_done(bc_done),
        .rect_x(b_rect_x), .rect_y(b_rect_y), .rect_colour(b_col), .pos_x(b_pos_x), .pos_y(b_pos_y),
        .busy(b_busy), .frame_overrun(b_ovr));

    box_motion_sequencer #(.SCREEN_W(40), .SCREEN_H(30), .FRAME_TICKS(20), .START_X(30), .START_Y(20)) dut_c (
        .clock(clock), .resetn(bc_resetn), .enable(bc_enable), .draw_start(c_start), .draw_done(bc_done),
        .rect_x(c_rect_x), .rect_y(c_rect_y), .rect_colour(c_col), .pos_x(c_pos_x), .pos_y(c_pos_y),
        .busy(c_busy), .frame_overrun(c_ovr));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic wait_start(input int sel, input int bound, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!(sel != 0 ? b_start : a_start) && n < bound);
        if (!(sel != 0 ? b_start : a_start)) check("start_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse(input int sel);
        if (sel != 0) bc_done = 1'b1; else draw_done = 1'b1;
        step();
        bc_done = 1'b0;
        draw_done = 1'b0;
    endtask

    task automatic frame(input int sel, input int ox, input int oy, input int nx, input int ny);
        int n;
        wait_start(sel, 100, n);
        check("erase_x", sel != 0 ? b_rect_x : a_rect_x, ox);
        check("erase_y", sel != 0 ? b_rect_y : a_rect_y, oy);
        check("erase_col", sel != 0 ? b_col : a_col, 0);
        repeat (4) step();
        check("erase_rect_hold", sel != 0 ? b_rect_x : a_rect_x, ox);
        pulse(sel);
        wait_start(sel, 10, n);
        check("draw_latency", n, 1);
        check("draw_x", sel != 0 ? b_rect_x : a_rect_x, nx);
        check("draw_y", sel != 0 ? b_rect_y : a_rect_y, ny);
        check("draw_col", sel != 0 ? b_col : a_col, 1);
        check("pos_x", sel != 0 ? b_pos_x : a_pos_x, nx);
        check("pos_y", sel != 0 ? b_pos_y : a_pos_y, ny);
        repeat (4) step();
        pulse(sel);
    endtask

    initial begin
        int n, cnt;
        resetn = 1'b0; enable = 1'b0; draw_done = 1'b0;
        bc_resetn = 1'b0; bc_enable = 1'b0; bc_done = 1'b0;
        repeat (3) step();
        check("rst_start", a_start, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ovr", a_ovr, 0);
        check("rst_pos_x", a_pos_x, 0);
        check("rst_pos_y", a_pos_y, 0);
        check("rst_col", a_col, 0);

        resetn = 1'b1; enable = 1'b1;
        step();
        check("init_start", a_start, 1);
        check("init_x", a_rect_x, 0);
        check("init_y", a_rect_y, 0);
        check("init_col", a_col, 1);
        check("init_busy", a_busy, 1);
        repeat (4) step();
        check("init_start_once", a_start, 0);
        check("init_busy_wait", a_busy, 1);
        pulse(0);
        check("init_idle_busy", a_busy, 0);

        frame(0, 0, 0, 1, 1);
        frame(0, 1, 1, 2, 2);

        // engine stalls on the erase for three frame periods
        wait_start(0, 100, n);
        check("stall_erase_x", a_rect_x, 2);
        check("stall_erase_col", a_col, 0);
        cnt = 0;
        repeat (60) begin
            step();
            if (a_start) cnt++;
        end
        check("stall_no_restart", cnt, 0);
        check("stall_busy", a_busy, 1);
        check("overrun", a_ovr, 1);
        pulse(0);
        wait_start(0, 10, n);
        check("stall_draw_lat", n, 1);
        check("stall_draw_x", a_rect_x, 3);
        check("stall_draw_col", a_col, 1);
        repeat (4) step();
        pulse(0);
        wait_start(0, 10, n);
        check("pending_erase_lat", n, 1);
        check("pending_erase_x", a_rect_x, 3);
        check("pending_erase_col", a_col, 0);
        repeat (4) step();
        pulse(0);
        wait_start(0, 10, n);
        check("resume_draw_x", a_rect_x, 4);
        repeat (4) step();
        pulse(0);
        check("overrun_sticky", a_ovr, 1);

        // enable low parks the box in WAIT_TICK
        enable = 1'b0;
        cnt = 0;
        repeat (60) begin
            step();
            if (a_start) cnt++;
        end
        check("hold_no_start", cnt, 0);
        check("hold_busy", a_busy, 0);
        check("hold_pos_x", a_pos_x, 4);
        enable = 1'b1;
        wait_start(0, 100, n);
        check("resume_is_erase", a_col, 0);
        check("resume_erase_x", a_rect_x, 4);

        // reset during ERASE_WAIT abandons the request
        repeat (2) step();
        check("pre_rst_busy", a_busy, 1);
        resetn = 1'b0;
        #1;
        check("arst_busy", a_busy, 0);
        check("arst_start", a_start, 0);
        check("arst_pos_x", a_pos_x, 0);
        check("arst_pos_y", a_pos_y, 0);
        check("arst_ovr", a_ovr, 0);
        check("arst_rect_x", a_rect_x, 0);
        check("arst_col", a_col, 0);
        enable = 1'b0;
        step();
        resetn = 1'b1;
        step();
        pulse(0);
        cnt = 0;
        repeat (5) begin
            step();
            if (a_start) cnt++;
        end
        check("stray_done_ignored", cnt, 0);
        check("stray_busy", a_busy, 0);
        enable = 1'b1;
        step();
        check("fresh_start", a_start, 1);
        check("fresh_x", a_rect_x, 0);
        check("fresh_col", a_col, 1);

        // bounce instances: 40x30 screen, starts (30,19) and corner (30,20)
        bc_resetn = 1'b1; bc_enable = 1'b1;
        wait_start(1, 10, n);
        check("b_init_x", b_rect_x, 30);
        check("b_init_y", b_rect_y, 19);
        check("c_init_start", c_start, 1);
        check("c_init_y", c_rect_y, 20);
        repeat (4) step();
        pulse(1);
        frame(1, 30, 19, 29, 20);
        check("c_pos_x1", c_pos_x, 29);
        check("c_pos_y1", c_pos_y, 19);
        frame(1, 29, 20, 28, 19);
        check("c_pos_x2", c_pos_x, 28);
        check("c_pos_y2", c_pos_y, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/box_motion_sequencer.md
Name: box_motion_sequencer

Overview:
- Upstream command stage for the rectangle draw engine that emits x/y to the VGA adapter (480x360, 3-bit colour).
- On every frame tick it commands an erase of the box at its old position in the background colour.
- It then advances the box position one pixel per axis, bouncing off the screen edges, and commands a redraw in the box colour.
- Handshake with the engine is a start pulse plus a done pulse.

Parameters:
- SCREEN_W, 480, visible width in pixels
- SCREEN_H, 360, visible height in pixels
- BOX_SIZE, 10, square box edge in pixels
- FRAME_TICKS, 833333, clock cycles per frame tick (50 MHz / 60 Hz)
- BOX_COLOUR, 3'b001, draw colour
- BG_COLOUR, 3'b000, erase colour
- START_X, 0, initial box x (must be in 0..SCREEN_W-BOX_SIZE)
- START_Y, 0, initial box y (must be in 0..SCREEN_H-BOX_SIZE)

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  asynchronous active-low reset
- enable  in  1  run request; level-sensitive
- draw_start  out  1  one-cycle pulse requesting one rectangle fill
- draw_done  in  1  one-cycle pulse from the engine; the fill is complete
- rect_x  out  10  rectangle origin x for the engine
- rect_y  out  9  rectangle origin y for the engine
- rect_colour  out  3  fill colour for the engine
- pos_x  out  10  current box x
- pos_y  out  9  current box y
- busy  out  1  high while an erase or draw is outstanding
- frame_overrun  out  1  sticky flag: a frame tick was dropped

Behaviour:
- Reset (async, resetn=0) forces the following immediately:
  - state IDLE
  - draw_start=0, busy=0, frame_overrun=0
  - pos_x=START_X, pos_y=START_Y
  - rect_x=START_X, rect_y=START_Y, rect_colour=BG_COLOUR
  - dir_x=+1, dir_y=+1
  - tick counter=0, tick_pending=0
- Reset mid-operation abandons any outstanding request. A later draw_done is ignored.
- States: IDLE, DRAW_REQ, DRAW_WAIT, WAIT_TICK, ERASE_REQ, ERASE_WAIT, UPDATE.
- IDLE: when enable=1, go to DRAW_REQ (initial draw, no erase).
- DRAW_REQ (1 cycle):
  - draw_start=1, rect_colour=BOX_COLOUR, rect_x/y=pos_x/y.
  - Next state DRAW_WAIT.
- ERASE_REQ (1 cycle):
  - draw_start=1, rect_colour=BG_COLOUR, rect_x/y=pos_x/y (old position).
  - Next state ERASE_WAIT.
- DRAW_WAIT / ERASE_WAIT:
  - rect_* held stable.
  - On draw_done go to WAIT_TICK / UPDATE respectively.
  - draw_done is sampled only in the WAIT states and ignored elsewhere.
- busy=1 in the REQ and WAIT states.
- UPDATE (1 cycle), per axis independently (x shown; y identical with SCREEN_H):
  - dir=+1 and pos_x==SCREEN_W-BOX_SIZE: dir_x<=-1, pos_x<=pos_x-1.
  - dir=-1 and pos_x==0: dir_x<=+1, pos_x<=pos_x+1.
  - Otherwise pos_x<=pos_x+dir_x.
  - A corner hit flips both axes in the same cycle.
  - Position never leaves 0..SCREEN-BOX_SIZE.
  - Next state DRAW_REQ.
- WAIT_TICK: if (tick_pending or tick this cycle) and enable=1, go to ERASE_REQ and clear tick_pending.
- Tick counter:
  - Counts 0..FRAME_TICKS-1 while state!=IDLE and enable=1; frozen otherwise.
  - tick=1 on the cycle the counter equals FRAME_TICKS-1; the counter wraps to 0.
- Tick outside WAIT_TICK sets tick_pending (one deep).
- Tick while tick_pending=1 and not consumed: frame_overrun<=1, sticky until reset.
- enable=0:
  - An in-flight erase/update/draw completes normally.
  - The sequencer then holds in WAIT_TICK with the box visible.
  - Re-asserting enable resumes; no re-initial draw.
- draw_start never asserts twice without an intervening draw_done.
- Latency: tick to erase draw_start is 1 cycle. Erase draw_done to draw draw_start is 2 cycles (UPDATE, DRAW_REQ).

Test Plan:
- Reset release, enable=1, FRAME_TICKS=20, START=(0,0) -> next cycle draw_start=1 with rect=(0,0), colour=001; busy=1 until draw_done.
- Steady run, engine done 5 cycles after start -> each tick: erase pulse at (x,y) colour 000, then draw pulse at (x+1,y+1) colour 001; pos advances (0,0)->(1,1)->(2,2).
- SCREEN_W=40, SCREEN_H=30, BOX_SIZE=10, START=(30,19), dir +,+ -> after UPDATE pos=(29,20), dir_x=-1; from (29,20), y reaches 20 boundary next -> pos=(28,19), dir_y=-1.
- Corner start=(30,20) -> single UPDATE yields (29,19), both dirs flipped.
- Engine withholds draw_done for 3*FRAME_TICKS -> frame_overrun=1; no second draw_start before done; sequence resumes with one erase/draw.
- Assert resetn=0 during ERASE_WAIT, then a stray draw_done after release -> outputs at reset values, state IDLE, stray done ignored; enable gives a fresh initial draw at START.
